// File: rtl/i2s_peak_bargraph.sv
// Peak meter behind the I2S deserializer: per-channel |sample| peak with
// hold-then-decay ballistics, mapped to a 6 dB/segment thermometer bar.
//
// Ports:
//   BIT_CK        clock, rising edge
//   RESET         synchronous, active-high
//   DATA_L/R      two's complement samples from the deserializer
//   STROBE        level-valid; one sample accepted per high period
//   STROBE_LR     channel of latest sample (1 = right)
//   BAR_L/R       thermometer bars, bit k = segment k
//   CLIP_L/R      clip indicators, held HOLD_SAMPLES channel samples
//   BAR_VALID     one-cycle pulse, 3 cycles after accept
//   BAR_VALID_LR  channel of that update (1 = right)
module i2s_peak_bargraph #(
    parameter int WIDTH        = 16,
    parameter int SEGMENTS     = 8,
    parameter int HOLD_SAMPLES = 2400,
    parameter int DECAY_SHIFT  = 6
) (
    input  logic                BIT_CK,
    input  logic                RESET,
    input  logic [WIDTH-1:0]    DATA_L,
    input  logic [WIDTH-1:0]    DATA_R,
    input  logic                STROBE,
    input  logic                STROBE_LR,
    output logic [SEGMENTS-1:0] BAR_L,
    output logic [SEGMENTS-1:0] BAR_R,
    output logic                CLIP_L,
    output logic                CLIP_R,
    output logic                BAR_VALID,
    output logic                BAR_VALID_LR
);

    localparam int MW = WIDTH - 1;
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_SAMPLES);

    // Stage 0: accept on STROBE rising edge
    logic             r_strobe_d;
    logic             r_s0_vld;
    logic             r_s0_ch;
    logic [WIDTH-1:0] r_s0_smp;
    logic             w_accept;

    assign w_accept = STROBE & ~r_strobe_d;

    always_ff @(posedge BIT_CK) begin
        if (RESET) begin
            r_strobe_d <= 1'b0;
            r_s0_vld   <= 1'b0;
            r_s0_ch    <= 1'b0;
            r_s0_smp   <= '0;
        end else begin
            r_strobe_d <= STROBE;
            r_s0_vld   <= w_accept;
            if (w_accept) begin
                r_s0_ch  <= STROBE_LR;
                r_s0_smp <= STROBE_LR ? DATA_R : DATA_L;
            end
        end
    end

    // Stage 1: magnitude, most-negative saturates to max positive
    logic             w_is_min;
    logic             w_is_max;
    logic [WIDTH-1:0] w_abs;
    logic [MW-1:0]    w_mag;
    logic             r_s1_vld;
    logic             r_s1_ch;
    logic             r_s1_clip;
    logic [MW-1:0]    r_s1_mag;

    assign w_is_min = (r_s0_smp == {1'b1, {MW{1'b0}}});
    assign w_is_max = (r_s0_smp == {1'b0, {MW{1'b1}}});
    assign w_abs    = r_s0_smp[WIDTH-1] ? ({WIDTH{1'b0}} - r_s0_smp)
                                        : r_s0_smp;
    assign w_mag    = w_is_min ? {MW{1'b1}} : w_abs[MW-1:0];

    always_ff @(posedge BIT_CK) begin
        if (RESET) begin
            r_s1_vld  <= 1'b0;
            r_s1_ch   <= 1'b0;
            r_s1_clip <= 1'b0;
            r_s1_mag  <= '0;
        end else begin
            r_s1_vld  <= r_s0_vld;
            r_s1_ch   <= r_s0_ch;
            r_s1_clip <= w_is_min | w_is_max;
            r_s1_mag  <= w_mag;
        end
    end

    // Stage 2: peak / hold / clip update of the selected channel
    logic [MW-1:0] r_peak_l, r_peak_r;
    logic [HW-1:0] r_hold_l, r_hold_r;
    logic [HW-1:0] r_ccnt_l, r_ccnt_r;
    logic          r_clip_l, r_clip_r;
    logic          r_s2_vld;
    logic          r_s2_ch;

    logic [MW-1:0] w_peak_cur, w_peak_nx, w_dec, w_sub;
    logic [HW-1:0] w_hold_cur, w_hold_nx;
    logic [HW-1:0] w_ccnt_cur, w_ccnt_nx;
    logic          w_clip_cur, w_clip_nx;

    assign w_peak_cur = r_s1_ch ? r_peak_r : r_peak_l;
    assign w_hold_cur = r_s1_ch ? r_hold_r : r_hold_l;
    assign w_ccnt_cur = r_s1_ch ? r_ccnt_r : r_ccnt_l;
    assign w_clip_cur = r_s1_ch ? r_clip_r : r_clip_l;

    always_comb begin
        w_peak_nx = w_peak_cur;
        w_hold_nx = w_hold_cur;
        w_dec     = w_peak_cur >> DECAY_SHIFT;
        if (w_dec == '0)
            w_dec = MW'(1);
        w_sub = (w_peak_cur > w_dec) ? (w_peak_cur - w_dec) : '0;
        if (r_s1_mag > w_peak_cur) begin
            w_peak_nx = r_s1_mag;
            w_hold_nx = HOLD_LD;
        end else if (w_hold_cur != '0) begin
            w_hold_nx = w_hold_cur - HW'(1);
        end else begin
            // decay never drops below the current sample
            w_peak_nx = (w_sub > r_s1_mag) ? w_sub : r_s1_mag;
        end
    end

    always_comb begin
        w_ccnt_nx = w_ccnt_cur;
        w_clip_nx = w_clip_cur;
        if (r_s1_clip) begin
            w_ccnt_nx = HOLD_LD;
            w_clip_nx = 1'b1;
        end else if (w_ccnt_cur != '0) begin
            w_ccnt_nx = w_ccnt_cur - HW'(1);
        end else begin
            w_clip_nx = 1'b0;
        end
    end

    always_ff @(posedge BIT_CK) begin
        if (RESET) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_ccnt_l <= '0;
            r_ccnt_r <= '0;
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_ch  <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_ch  <= r_s1_ch;
            if (r_s1_vld) begin
                if (r_s1_ch) begin
                    r_peak_r <= w_peak_nx;
                    r_hold_r <= w_hold_nx;
                    r_ccnt_r <= w_ccnt_nx;
                    r_clip_r <= w_clip_nx;
                end else begin
                    r_peak_l <= w_peak_nx;
                    r_hold_l <= w_hold_nx;
                    r_ccnt_l <= w_ccnt_nx;
                    r_clip_l <= w_clip_nx;
                end
            end
        end
    end

    // Stage 3: log-scale thermometer, one octave per segment
    logic [MW-1:0]       w_bar_src;
    logic [SEGMENTS-1:0] w_bar;
    logic [SEGMENTS-1:0] r_bar_l, r_bar_r;
    logic                r_bv, r_bv_lr;

    assign w_bar_src = r_s2_ch ? r_peak_r : r_peak_l;

    always_comb begin
        w_bar = '0;
        for (int k = 0; k < SEGMENTS; k++)
            w_bar[k] = (w_bar_src >= (MW'(1) << (WIDTH - 1 - SEGMENTS + k)));
    end

    always_ff @(posedge BIT_CK) begin
        if (RESET) begin
            r_bar_l <= '0;
            r_bar_r <= '0;
            r_bv    <= 1'b0;
            r_bv_lr <= 1'b0;
        end else begin
            r_bv <= r_s2_vld;
            if (r_s2_vld) begin
                r_bv_lr <= r_s2_ch;
                if (r_s2_ch)
                    r_bar_r <= w_bar;
                else
                    r_bar_l <= w_bar;
            end
        end
    end

    assign BAR_L        = r_bar_l;
    assign BAR_R        = r_bar_r;
    assign CLIP_L       = r_clip_l;
    assign CLIP_R       = r_clip_r;
    assign BAR_VALID    = r_bv;
    assign BAR_VALID_LR = r_bv_lr;

endmodule

// File: tb/tb_i2s_peak_bargraph.sv
// Directed bench for i2s_peak_bargraph: instance A uses default
// ballistics, instance B uses HOLD_SAMPLES=2, DECAY_SHIFT=1.
module tb_i2s_peak_bargraph;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dl  = '0;
    logic [15:0] dr  = '0;
    logic        stb = 1'b0;
    logic        slr = 1'b0;

    logic [7:0] a_bl, a_br, b_bl, b_br;
    logic       a_cl, a_cr, a_v, a_vlr;
    logic       b_cl, b_cr, b_v, b_vlr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int a_cnt, b_cnt, a_at, b_at, t0;
    logic a_lr, b_lr;

    always #5 clk = ~clk;

    i2s_peak_bargraph u_a (
        .BIT_CK(clk), .RESET(rst), .DATA_L(dl), .DATA_R(dr),
        .STROBE(stb), .STROBE_LR(slr),
        .BAR_L(a_bl), .BAR_R(a_br), .CLIP_L(a_cl), .CLIP_R(a_cr),
        .BAR_VALID(a_v), .BAR_VALID_LR(a_vlr)
    );

    i2s_peak_bargraph #(.HOLD_SAMPLES(2), .DECAY_SHIFT(1)) u_b (
        .BIT_CK(clk), .RESET(rst), .DATA_L(dl), .DATA_R(dr),
        .STROBE(stb), .STROBE_LR(slr),
        .BAR_L(b_bl), .BAR_R(b_br), .CLIP_L(b_cl), .CLIP_R(b_cr),
        .BAR_VALID(b_v), .BAR_VALID_LR(b_vlr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the edge
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (a_v === 1'b1) begin
            a_cnt++;
            a_at = cyc;
            a_lr = a_vlr;
        end
        if (b_v === 1'b1) begin
            b_cnt++;
            b_at = cyc;
            b_lr = b_vlr;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        stb = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // One strobe period of n edges; data changes after accept and the
    // unselected channel carries full scale, neither may leak through.
    task automatic send(input logic ch, input logic [15:0] d,
                        input int n);
        slr = ch;
        if (ch) begin
            dr = d;
            dl = 16'h7FFF;
        end else begin
            dl = d;
            dr = 16'h7FFF;
        end
        stb   = 1'b1;
        a_cnt = 0;
        b_cnt = 0;
        a_at  = 0;
        b_at  = 0;
        t0    = cyc;
        tick();
        dl = 16'h7FFF;
        dr = 16'h7FFF;
        repeat (n - 1) tick();
        stb = 1'b0;
        tick();
        chk("a_pulses", a_cnt, 1);
        chk("a_latency", a_at - t0, 4);
        chk("a_lr", a_lr, ch);
        chk("b_pulses", b_cnt, 1);
        chk("b_lr", b_lr, ch);
    endtask

    initial begin
        // reset held with STROBE high
        rst = 1'b1;
        stb = 1'b1;
        slr = 1'b0;
        dl  = 16'h0100;
        repeat (3) tick();
        chk("rst_bar_l", a_bl, 8'h00);
        chk("rst_bar_r", a_br, 8'h00);
        chk("rst_clip_l", a_cl, 1'b0);
        chk("rst_clip_r", a_cr, 1'b0);
        chk("rst_valid", a_v, 1'b0);
        chk("rst_b_valid", b_v, 1'b0);
        rst   = 1'b0;
        a_cnt = 0;
        a_at  = 0;
        t0    = cyc;
        repeat (8) tick();
        stb = 1'b0;
        tick();
        chk("rel_pulses", a_cnt, 1);
        chk("rel_latency", a_at - t0, 4);
        chk("rel_bar_l", a_bl, 8'h03);

        // left 0x4000, STROBE high 20 cycles
        do_reset();
        send(1'b0, 16'h4000, 20);
        chk("fs_bar_l", a_bl, 8'hFF);
        chk("fs_bar_r", a_br, 8'h00);
        chk("fs_clip_l", a_cl, 1'b0);
        chk("fs_b_bar_l", b_bl, 8'hFF);

        // thresholds and clip on right
        do_reset();
        send(1'b1, 16'd127, 4);
        chk("thr127_b", b_br, 8'h00);
        chk("thr127_a", a_br, 8'h00);
        send(1'b1, 16'd128, 4);
        chk("thr128_b", b_br, 8'h01);
        chk("thr128_a", a_br, 8'h01);
        send(1'b1, 16'hFF7F, 4);
        chk("thrm129_b", b_br, 8'h01);
        send(1'b1, 16'h0000, 4);
        send(1'b1, 16'h0000, 4);
        send(1'b1, 16'h0000, 4);
        chk("decay_b", b_br, 8'h00);
        chk("hold_a", a_br, 8'h01);
        send(1'b1, 16'h8000, 4);
        chk("min_bar_b", b_br, 8'hFF);
        chk("min_bar_a", a_br, 8'hFF);
        chk("min_clip_r", b_cr, 1'b1);
        chk("min_clip_l", b_cl, 1'b0);
        chk("min_bar_l", b_bl, 8'h00);

        // hold then decay, left
        do_reset();
        send(1'b0, 16'h4000, 4);
        chk("hd0", b_bl, 8'hFF);
        send(1'b0, 16'h0000, 4);
        chk("hd1", b_bl, 8'hFF);
        send(1'b0, 16'h0000, 4);
        chk("hd2", b_bl, 8'hFF);
        send(1'b0, 16'h0000, 4);
        chk("hd3", b_bl, 8'h7F);
        send(1'b0, 16'h0000, 4);
        chk("hd4", b_bl, 8'h3F);
        send(1'b0, 16'h0000, 4);
        chk("hd5", b_bl, 8'h1F);
        chk("hd5_a", a_bl, 8'hFF);

        // clip release, left, with a right clip in between
        do_reset();
        send(1'b0, 16'h7FFF, 4);
        chk("cl0", b_cl, 1'b1);
        send(1'b0, 16'h0000, 4);
        chk("cl1", b_cl, 1'b1);
        send(1'b1, 16'h8000, 4);
        chk("cl_r", b_cr, 1'b1);
        chk("cl_r_l", b_cl, 1'b1);
        send(1'b0, 16'h0000, 4);
        chk("cl2", b_cl, 1'b1);
        send(1'b0, 16'h0000, 4);
        chk("cl3", b_cl, 1'b0);
        chk("cl3_r", b_cr, 1'b1);

        // reset one cycle after accept
        do_reset();
        slr   = 1'b0;
        dl    = 16'h4000;
        stb   = 1'b1;
        a_cnt = 0;
        b_cnt = 0;
        tick();
        rst = 1'b1;
        stb = 1'b0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("mid_pulses", a_cnt, 0);
        chk("mid_b_pulses", b_cnt, 0);
        chk("mid_bar_l", a_bl, 8'h00);
        chk("mid_bar_r", a_br, 8'h00);
        chk("mid_clip_l", a_cl, 1'b0);
        send(1'b0, 16'h0100, 4);
        chk("mid_next_bar", a_bl, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
